// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - ISA encodings, sequencer states and decode class shared by the control unit
package mc_control_fsm_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD   = 4'd4;
  localparam logic [3:0] ALU_PASSA = 4'd14;
  localparam logic [3:0] ALU_RTYPE = 4'd15;

  localparam logic [1:0] PCS_PC1    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REG    = 2'd3;

  localparam logic [1:0] ASB_REG = 2'd0;
  localparam logic [1:0] ASB_ONE = 2'd1;
  localparam logic [1:0] ASB_IMM = 2'd2;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_R2 = 2'd2;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX, S_MEMR, S_MEMW, S_WB, S_BR, S_WWD, S_JPR, S_LINK, S_LWB, S_HALT
  } state_t;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic branch;
    logic jmp;
    logic jal;
    logic jrl;
    logic jpr;
    logic wwd;
    logic hlt;
    logic illegal;
  } inst_class_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control unit <-> datapath/memory signal bundle
interface mc_control_fsm_if #(parameter int CNT_W = 16);
  logic [15:0]      inst;
  logic             mem_ready;
  logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]       PCSource, ALUSrcB, RegDst;
  logic [3:0]       ALUOp;
  logic [5:0]       func;
  logic             is_wwd;
  logic             halt;
  logic [CNT_W-1:0] num_inst;

  modport master (
    input  inst, mem_ready,
    output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite,
    output PCSource, ALUSrcB, RegDst, ALUOp, func, is_wwd, halt, num_inst
  );

  modport slave (
    output inst, mem_ready,
    input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite,
    input  PCSource, ALUSrcB, RegDst, ALUOp, func, is_wwd, halt, num_inst
  );
endinterface

// File: rtl/mc_control_fsm_inst_class_decoder.sv
// rtl/mc_control_fsm_inst_class_decoder.sv - maps opcode/func to a one-hot instruction class
module inst_class_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  fn,
  output inst_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.branch = 1'b1;
      OP_ADI, OP_ORI, OP_LHI:         cls.alu_i  = 1'b1;
      OP_LWD:                         cls.load   = 1'b1;
      OP_SWD:                         cls.store  = 1'b1;
      OP_JMP:                         cls.jmp    = 1'b1;
      OP_JAL:                         cls.jal    = 1'b1;
      OP_RTYPE: begin
        if (fn < 6'd8)         cls.alu_r   = 1'b1;
        else if (fn == FN_JPR) cls.jpr     = 1'b1;
        else if (fn == FN_JRL) cls.jrl     = 1'b1;
        else if (fn == FN_WWD) cls.wwd     = 1'b1;
        else if (fn == FN_HLT) cls.hlt     = 1'b1;
        else                   cls.illegal = 1'b1;
      end
      default:                        cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle sequencer driving the 16-bit datapath controls
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  mc_control_fsm_if.master   bus
);

  state_t           state, state_nx;
  inst_class_t      cls;
  logic             retire;
  logic [CNT_W-1:0] num_q;
  logic             halt_q;

  inst_class_decoder u_dec (
    .opcode (bus.inst[15:12]),
    .fn     (bus.inst[5:0]),
    .cls    (cls)
  );

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_IF:   if (bus.mem_ready) state_nx = S_ID;
      S_ID: begin
        if (cls.jmp || cls.illegal) begin
          state_nx = S_IF;
          retire   = 1'b1;
        end
        else if (cls.jal || cls.jrl)                          state_nx = S_LINK;
        else if (cls.branch)                                  state_nx = S_BR;
        else if (cls.alu_i || cls.alu_r || cls.load || cls.store) state_nx = S_EX;
        else if (cls.wwd)                                     state_nx = S_WWD;
        else if (cls.jpr)                                     state_nx = S_JPR;
        else if (cls.hlt) begin
          state_nx = S_HALT;
          retire   = 1'b1;
        end
        else begin
          state_nx = S_IF;
          retire   = 1'b1;
        end
      end
      S_EX:   state_nx = cls.load ? S_MEMR : (cls.store ? S_MEMW : S_WB);
      S_MEMR: if (bus.mem_ready) state_nx = S_WB;
      S_MEMW: if (bus.mem_ready) begin
        state_nx = S_IF;
        retire   = 1'b1;
      end
      S_LINK: state_nx = S_LWB;
      S_WB, S_BR, S_WWD, S_JPR, S_LWB: begin
        state_nx = S_IF;
        retire   = 1'b1;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IF;
      num_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (retire) num_q <= num_q + CNT_W'(1);
      if (state_nx == S_HALT) halt_q <= 1'b1;
    end
  end

  assign bus.num_inst = num_q;
  assign bus.halt     = halt_q;

  // Controls are decoded from state (plus mem_ready in fetch) and forced low while reset is held.
  always_comb begin
    bus.PCWriteCond = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.PCSource    = PCS_PC1;
    bus.ALUSrcB     = ASB_REG;
    bus.RegDst      = RD_RT;
    bus.ALUOp       = 4'd0;
    bus.func        = 6'd0;
    bus.is_wwd      = 1'b0;
    if (reset_n) begin
      case (state)
        S_IF: begin
          bus.MemRead = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
            bus.ALUSrcB = ASB_ONE;
            bus.ALUOp   = ALU_ADD;
          end
        end
        S_ID: begin
          bus.ALUSrcB = ASB_IMM;
          bus.ALUOp   = ALU_ADD;
          if (cls.jmp) begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = PCS_JUMP;
          end
        end
        S_BR: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = bus.inst[15:12];
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = PCS_ALUOUT;
        end
        S_EX: begin
          bus.ALUSrcA = 1'b1;
          if (cls.alu_r) begin
            bus.ALUOp = ALU_RTYPE;
            bus.func  = bus.inst[5:0];
          end else begin
            bus.ALUSrcB = ASB_IMM;
            bus.ALUOp   = (cls.load || cls.store) ? ALU_ADD : bus.inst[15:12];
          end
        end
        S_MEMR: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        S_MEMW: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = cls.alu_r ? RD_RD : RD_RT;
          bus.MemtoReg = cls.load;
        end
        S_WWD: begin
          bus.ALUOp  = ALU_RTYPE;
          bus.func   = FN_WWD;
          bus.is_wwd = 1'b1;
        end
        S_JPR: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = PCS_REG;
        end
        S_LINK: bus.ALUOp = ALU_PASSA;
        S_LWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = RD_R2;
          bus.PCWrite  = 1'b1;
          bus.PCSource = cls.jrl ? PCS_REG : PCS_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - instruction-level reference model and per-cycle checker for mc_control_fsm
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, asa, rw;
    logic [1:0] pcs, asb, rdst;
    logic [3:0] aop;
    logic [5:0] fn;
    logic wwd;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(CW)) bus();
  mc_control_fsm #(.CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  ctl_t exp_ctl;
  logic exp_halt;
  logic [CW-1:0] exp_num;
  logic [CW-1:0] m_num;
  logic m_halt;
  int cnt_memread, cnt_irwrite, cnt_iord, cnt_wwd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ctl_t actual();
    ctl_t a;
    a.pcwc = bus.PCWriteCond; a.pcw = bus.PCWrite; a.iord = bus.IorD;
    a.mrd = bus.MemRead; a.mwr = bus.MemWrite; a.m2r = bus.MemtoReg;
    a.irw = bus.IRWrite; a.asa = bus.ALUSrcA; a.rw = bus.RegWrite;
    a.pcs = bus.PCSource; a.asb = bus.ALUSrcB; a.rdst = bus.RegDst;
    a.aop = bus.ALUOp; a.fn = bus.func; a.wwd = bus.is_wwd;
    return a;
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("ctl", 64'(actual()), 64'(exp_ctl));
      check("halt", 64'(bus.halt), 64'(exp_halt));
      check("num_inst", 64'(bus.num_inst), 64'(exp_num));
      if (bus.MemRead) cnt_memread++;
      if (bus.IRWrite) cnt_irwrite++;
      if (bus.IorD) cnt_iord++;
      if (bus.is_wwd) cnt_wwd++;
    end
  end

  task automatic step(input ctl_t c, input logic mr, input logic [15:0] ir);
    @(negedge clk);
    bus.mem_ready = mr;
    bus.inst = ir;
    exp_ctl = c;
    exp_halt = m_halt;
    exp_num = m_num;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset_n = 1'b0;
      m_num = '0;
      m_halt = 1'b0;
      bus.mem_ready = 1'($urandom);
      bus.inst = 16'($urandom);
      exp_ctl = '0;
      exp_halt = 1'b0;
      exp_num = '0;
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Each instruction is a fetch (with wait), a decode, then the steps its class needs.
  task automatic run_inst(input logic [15:0] ir, input int fw, input int mw, input bit abort_mem);
    ctl_t c;
    logic [3:0] op;
    logic [5:0] fn;
    bit r;
    op = ir[15:12];
    fn = ir[5:0];
    r = (op == 4'd15);
    c = '0; c.mrd = 1'b1;
    for (int i = 0; i < fw; i++) step(c, 1'b0, 16'($urandom));
    c.irw = 1'b1; c.pcw = 1'b1; c.asb = 2'd1; c.aop = ALU_ADD;
    step(c, 1'b1, 16'($urandom));
    c = '0; c.asb = 2'd2; c.aop = ALU_ADD;
    if (op == 4'd9) begin c.pcw = 1'b1; c.pcs = 2'd2; end
    step(c, 1'($urandom), ir);
    if (op <= 4'd3) begin
      c = '0; c.asa = 1'b1; c.aop = op; c.pcwc = 1'b1; c.pcs = 2'd1;
      step(c, 1'($urandom), ir);
    end else if (op >= 4'd4 && op <= 4'd8) begin
      c = '0; c.asa = 1'b1; c.asb = 2'd2; c.aop = (op >= 4'd7) ? 4'd4 : op;
      step(c, 1'($urandom), ir);
      if (op == 4'd7) begin
        c = '0; c.iord = 1'b1; c.mrd = 1'b1;
        for (int i = 0; i < mw; i++) step(c, 1'b0, ir);
        step(c, 1'b1, ir);
        c = '0; c.rw = 1'b1; c.m2r = 1'b1;
        step(c, 1'($urandom), ir);
      end else if (op == 4'd8) begin
        c = '0; c.iord = 1'b1; c.mwr = 1'b1;
        for (int i = 0; i < mw; i++) step(c, 1'b0, ir);
        if (abort_mem) begin
          do_reset(2);
          return;
        end
        step(c, 1'b1, ir);
      end else begin
        c = '0; c.rw = 1'b1;
        step(c, 1'($urandom), ir);
      end
    end else if (op == 4'd10 || (r && fn == 6'd26)) begin
      c = '0; c.aop = ALU_PASSA;
      step(c, 1'($urandom), ir);
      c = '0; c.rw = 1'b1; c.rdst = 2'd2; c.pcw = 1'b1; c.pcs = (op == 4'd10) ? 2'd2 : 2'd3;
      step(c, 1'($urandom), ir);
    end else if (r && fn < 6'd8) begin
      c = '0; c.asa = 1'b1; c.aop = 4'd15; c.fn = fn;
      step(c, 1'($urandom), ir);
      c = '0; c.rw = 1'b1; c.rdst = 2'd1;
      step(c, 1'($urandom), ir);
    end else if (r && fn == 6'd25) begin
      c = '0; c.pcw = 1'b1; c.pcs = 2'd3;
      step(c, 1'($urandom), ir);
    end else if (r && fn == 6'd28) begin
      c = '0; c.aop = 4'd15; c.fn = 6'd28; c.wwd = 1'b1;
      step(c, 1'($urandom), ir);
    end else if (r && fn == 6'd29) begin
      m_num = m_num + 1'b1;
      m_halt = 1'b1;
      for (int i = 0; i < 4; i++) step('0, 1'($urandom), 16'($urandom));
      return;
    end
    m_num = m_num + 1'b1;
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 2) == 0) v[15:12] = 4'd15;
    if (v[15:12] == 4'd15) begin
      case ($urandom_range(0, 11))
        0: v[5:0] = 6'd25;
        1: v[5:0] = 6'd26;
        2: v[5:0] = 6'd28;
        3: v[5:0] = 6'd30;
        4: v[5:0] = 6'd12;
        default: v[5:0] = 6'($urandom_range(0, 7));
      endcase
    end
    return v;
  endfunction

  task automatic lit_point();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.inst = '0;
    bus.mem_ready = 1'b0;
    m_num = '0;
    m_halt = 1'b0;
    exp_ctl = '0;
    exp_halt = 1'b0;
    exp_num = '0;
    cnt_memread = 0; cnt_irwrite = 0; cnt_iord = 0; cnt_wwd = 0;
    chk_en = 1'b1;
    do_reset(3);

    cnt_memread = 0; cnt_irwrite = 0;
    run_inst(16'hF6C0, 3, 0, 1'b0);
    lit_point();
    check("lit_add_num", 64'(bus.num_inst), 64'd1);
    check("lit_fetch_memread", 64'(cnt_memread), 64'd4);
    check("lit_fetch_irwrite", 64'(cnt_irwrite), 64'd1);

    cnt_iord = 0;
    run_inst(16'h7104, 0, 2, 1'b0);
    lit_point();
    check("lit_lwd_iord", 64'(cnt_iord), 64'd3);
    check("lit_lwd_num", 64'(bus.num_inst), 64'd2);

    run_inst(16'h1234, 1, 0, 1'b0);
    run_inst(16'h1234, 0, 0, 1'b0);
    run_inst(16'hFA1A, 0, 0, 1'b0);
    lit_point();
    check("lit_jrl_num", 64'(bus.num_inst), 64'd5);

    for (int k = 0; k < 120; k++)
      run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

    lit_point();
    cnt_wwd = 0;
    run_inst(16'hF01C, 0, 0, 1'b0);
    lit_point();
    check("lit_wwd_pulse", 64'(cnt_wwd), 64'd1);

    run_inst(16'hF01D, 1, 0, 1'b0);
    lit_point();
    check("lit_halt_sticky", 64'(bus.halt), 64'd1);

    do_reset(2);
    check("lit_reset_num", 64'(bus.num_inst), 64'd0);
    run_inst(16'hF6C0, 0, 0, 1'b0);
    run_inst(16'h8104, 1, 3, 1'b1);
    check("lit_abort_num", 64'(bus.num_inst), 64'd0);
    check("lit_abort_halt", 64'(bus.halt), 64'd0);
    run_inst(16'hF6C0, 2, 0, 1'b0);
    lit_point();
    check("lit_after_abort_num", 64'(bus.num_inst), 64'd1);

    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
